// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, one clocked write port, same-cycle write bypass
// and a per-register pending-write scoreboard. Optional macro: REGFILE_SCOREBOARD_ZERO_REG_EN.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic                   iss_ready,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    output logic                   pend_any,
    output logic                   sb_err
);

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W+1)'(NREGS);
`ifdef REGFILE_SCOREBOARD_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q  [NREGS];
    logic [CNT_W-1:0]  cnt_d  [NREGS];
    logic              sb_err_q, sb_err_d;

    logic              iss_ok, wr_ok, inc, dec;
    logic [CNT_W-1:0]  iss_cnt, wr_cnt;

    // An address is backed by real state only if in range and not the hardwired zero register
    function automatic logic backed(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_A) && !(ZERO_REG && (a == '0));
    endfunction

    // Read ports: bypass the in-flight write, and drop busy when that write retires the last pending entry
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            logic [ADDR_W-1:0] a;
            logic [CNT_W-1:0]  c;
            logic              v, hit;
            a   = rd_addr[i*ADDR_W +: ADDR_W];
            v   = backed(a);
            c   = v ? cnt_q[a] : '0;
            hit = wr_en && (wr_addr == a);
            if (v) rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : regs_q[a];
            rd_busy[i] = (c != '0) && !(hit && (c == CNT_ONE));
        end
    end

    // Issue acceptance and next-state for registers, counters and the sticky error
    always_comb begin
        iss_ok    = backed(iss_addr);
        wr_ok     = wr_en && backed(wr_addr);
        iss_cnt   = iss_ok ? cnt_q[iss_addr] : '0;
        wr_cnt    = wr_ok ? cnt_q[wr_addr] : '0;
        iss_ready = !((iss_cnt == CNT_MAX) && !(wr_en && (wr_addr == iss_addr)));
        inc       = iss_valid && iss_ready && iss_ok;
        dec       = wr_ok && (wr_cnt != '0);
        regs_d    = regs_q;
        cnt_d     = cnt_q;
        sb_err_d  = sb_err_q;

        if (wr_ok) regs_d[wr_addr] = wr_data;
        if (wr_ok && (wr_cnt == '0)) sb_err_d = 1'b1;

        if (flush) begin
            for (int r = 0; r < int'(NREGS); r++) cnt_d[r] = '0;
        end else begin
            // Increment then decrement so a same-register issue+retire nets to no change
            if (inc) cnt_d[iss_addr] = cnt_d[iss_addr] + CNT_ONE;
            if (dec) cnt_d[wr_addr]  = cnt_d[wr_addr] - CNT_ONE;
        end
    end

    always_comb begin
        pend_any = 1'b0;
        for (int r = 0; r < int'(NREGS); r++) pend_any = pend_any | (cnt_q[r] != '0);
    end

    assign sb_err = sb_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, scoreboard saturation, last-retire bypass,
// flush, zero register and underflow error.
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;

    logic                  clk;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_ready;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  flush;
    logic                  pend_any;
    logic                  sb_err;

    int checks = 0;
    int passes = 0;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .pend_any(pend_any), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        iss_valid = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        idle(); iss_valid = 1'b1; iss_addr = a; tick(); idle();
    endtask

    task automatic test_reset();
        settle();
        checks++; if (rd_data !== 64'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("FAIL reset_rd_busy: got %b want 00", rd_busy); else passes++;
        checks++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready: got %b want 1", iss_ready); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL reset_pend_any: got %b want 0", pend_any); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err: got %b want 0", sb_err); else passes++;
        @(negedge clk); reset = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        issue(5'd3);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd3, 5'd0};
        settle();
        checks++; if (rd_data[32 +: 32] !== 32'hDEAD_BEEF) $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data[32 +: 32]); else passes++;
        checks++; if (rd_busy[1] !== 1'b0) $display("FAIL bypass_busy: got %b want 0", rd_busy[1]); else passes++;
        checks++; if (pend_any !== 1'b1) $display("FAIL bypass_pend_before: got %b want 1", pend_any); else passes++;
        tick(); idle(); settle();
        checks++; if (rd_data[32 +: 32] !== 32'hDEAD_BEEF) $display("FAIL bypass_next_cycle: got %h want deadbeef", rd_data[32 +: 32]); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL bypass_pend_after: got %b want 0", pend_any); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL bypass_sb_err: got %b want 0", sb_err); else passes++;
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd0, 5'd7};
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1'b1; iss_addr = 5'd7; settle();
            checks++; if (iss_ready !== 1'b1) $display("FAIL sb_issue_ready%0d: got %b want 1", k, iss_ready); else passes++;
            tick();
        end
        settle();
        checks++; if (iss_ready !== 1'b0) $display("FAIL sb_full_ready: got %b want 0", iss_ready); else passes++;
        checks++; if (rd_busy[0] !== 1'b1) $display("FAIL sb_full_busy: got %b want 1", rd_busy[0]); else passes++;
        checks++; if (pend_any !== 1'b1) $display("FAIL sb_full_pend: got %b want 1", pend_any); else passes++;
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7; settle();
        checks++; if (iss_ready !== 1'b1) $display("FAIL sb_iss_ret_ready: got %b want 1", iss_ready); else passes++;
        checks++; if (rd_data[0 +: 32] !== 32'h7) $display("FAIL sb_iss_ret_data: got %h want 7", rd_data[0 +: 32]); else passes++;
        tick(); idle();
        iss_valid = 1'b1; iss_addr = 5'd7; settle();
        checks++; if (iss_ready !== 1'b0) $display("FAIL sb_still_full: got %b want 0", iss_ready); else passes++;
        idle();
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h70 + 32'(k); settle();
            checks++; if (rd_busy[0] !== (k != 2)) $display("FAIL sb_retire_busy%0d: got %b want %b", k, rd_busy[0], (k != 2)); else passes++;
            tick();
        end
        idle(); settle();
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL sb_drained_busy: got %b want 0", rd_busy[0]); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL sb_drained_pend: got %b want 0", pend_any); else passes++;
        checks++; if (rd_data[0 +: 32] !== 32'h72) $display("FAIL sb_drained_data: got %h want 72", rd_data[0 +: 32]); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL sb_drained_err: got %b want 0", sb_err); else passes++;
    endtask

    task automatic test_last_retire();
        issue(5'd9);
        rd_addr = {5'd0, 5'd9};
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234; settle();
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL last_retire_busy: got %b want 0", rd_busy[0]); else passes++;
        checks++; if (rd_data[0 +: 32] !== 32'h1234) $display("FAIL last_retire_data: got %h want 1234", rd_data[0 +: 32]); else passes++;
        checks++; if (pend_any !== 1'b1) $display("FAIL last_retire_pend: got %b want 1", pend_any); else passes++;
        tick(); idle(); settle();
        checks++; if (pend_any !== 1'b0) $display("FAIL last_retire_pend_after: got %b want 0", pend_any); else passes++;
    endtask

    task automatic test_flush();
        issue(5'd2); issue(5'd4); issue(5'd4);
        rd_addr = {5'd4, 5'd2}; settle();
        checks++; if (rd_busy !== 2'b11) $display("FAIL flush_busy_before: got %b want 11", rd_busy); else passes++;
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAA;
        tick(); idle(); settle();
        checks++; if (rd_busy !== 2'b00) $display("FAIL flush_busy_after: got %b want 00", rd_busy); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL flush_pend: got %b want 0", pend_any); else passes++;
        checks++; if (rd_data[32 +: 32] !== 32'hAA) $display("FAIL flush_write_kept: got %h want aa", rd_data[32 +: 32]); else passes++;
        rd_addr = {5'd6, 5'd6}; settle();
        checks++; if (rd_busy !== 2'b00) $display("FAIL flush_issue_dropped: got %b want 00", rd_busy); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL flush_sb_err: got %b want 0", sb_err); else passes++;
    endtask

    task automatic test_zero_reg();
        rd_addr = {5'd0, 5'd0};
`ifdef REGFILE_SCOREBOARD_ZERO_REG_EN
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5; settle();
        checks++; if (rd_data[0 +: 32] !== 32'h0) $display("FAIL zero_bypass: got %h want 0", rd_data[0 +: 32]); else passes++;
        tick(); idle();
        for (int k = 0; k < 4; k++) issue(5'd0);
        iss_valid = 1'b1; iss_addr = 5'd0; settle();
        checks++; if (iss_ready !== 1'b1) $display("FAIL zero_iss_ready: got %b want 1", iss_ready); else passes++;
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL zero_busy: got %b want 0", rd_busy[0]); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL zero_pend: got %b want 0", pend_any); else passes++;
        idle(); settle();
        checks++; if (rd_data[0 +: 32] !== 32'h0) $display("FAIL zero_read: got %h want 0", rd_data[0 +: 32]); else passes++;
`else
        issue(5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5;
        tick(); idle(); settle();
        checks++; if (rd_data[0 +: 32] !== 32'h5) $display("FAIL r0_read: got %h want 5", rd_data[0 +: 32]); else passes++;
`endif
        checks++; if (sb_err !== 1'b0) $display("FAIL zero_sb_err: got %b want 0", sb_err); else passes++;
    endtask

    task automatic test_underflow();
        rd_addr = {5'd0, 5'd11};
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h55; settle();
        checks++; if (sb_err !== 1'b0) $display("FAIL uf_err_before: got %b want 0", sb_err); else passes++;
        tick(); idle(); settle();
        checks++; if (sb_err !== 1'b1) $display("FAIL uf_err_set: got %b want 1", sb_err); else passes++;
        checks++; if (rd_data[0 +: 32] !== 32'h55) $display("FAIL uf_written: got %h want 55", rd_data[0 +: 32]); else passes++;
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL uf_busy: got %b want 0", rd_busy[0]); else passes++;
        tick(); tick();
        checks++; if (sb_err !== 1'b1) $display("FAIL uf_err_sticky: got %b want 1", sb_err); else passes++;
    endtask

    task automatic test_reset_mid();
        issue(5'd5); issue(5'd5);
        rd_addr = {5'd3, 5'd5}; settle();
        checks++; if (rd_busy[0] !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", rd_busy[0]); else passes++;
        #2; reset = 1'b0; #1;
        checks++; if (rd_data !== 64'h0) $display("FAIL rst_mid_data: got %h want 0", rd_data); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("FAIL rst_mid_busy: got %b want 00", rd_busy); else passes++;
        checks++; if (pend_any !== 1'b0) $display("FAIL rst_mid_pend: got %b want 0", pend_any); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL rst_mid_sb_err: got %b want 0", sb_err); else passes++;
        iss_valid = 1'b1; iss_addr = 5'd5; settle();
        checks++; if (iss_ready !== 1'b1) $display("FAIL rst_mid_iss_ready: got %b want 1", iss_ready); else passes++;
        idle();
        @(negedge clk); reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        rd_addr = '0;
        idle();
        #12;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_last_retire();
        test_flush();
        test_zero_reg();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
